mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the configurable multiplier. Accepts 16-bit operand pairs over a
//  valid/ready handshake and time-shares one 9x9 signed multiplier over the ALBL/ALBH/AHBL/AHBH
//  byte partial products. Sign-extends each partial product to 32 bits, aligns it and
//  accumulates it. Returns one 16x16 product (mode 0) or two packed 8x8 lane products (mode 1).
// PARAMETERS
//  SIGNED_EN  1   1: operands two's complement; 0: operands unsigned (high bytes zero-extended)
//  CNT_W      16  width of completed-operation counter op_count_o
// PORTS
//  clk_i        in   1      clock, all state changes on rising edge
//  rst_i        in   1      synchronous, active-high reset
//  in_valid_i   in   1      operand pair valid
//  in_ready_o   out  1      controller can accept operands (high only in IDLE)
//  mode_i       in   1      0: single 16x16; 1: dual 8x8 lanes (lane0=[7:0], lane1=[15:8])
//  a_i          in   16     multiplicand
//  b_i          in   16     multiplier
//  res_valid_o  out  1      result valid, held until accepted
//  res_ready_i  in   1      downstream accepts result
//  result_o     out  32     product; mode 1: {lane1[15:0], lane0[15:0]}
//  busy_o       out  1      high in any state except IDLE
//  op_count_o   out  CNT_W  number of results handed off; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE; in_ready_o=1; res_valid_o=0; busy_o=0; result_o=0; op_count_o=0;
//   accumulator=0; operand registers=0.
//  FSM: IDLE -> PP0 -> PP1 -> PP2 -> PP3 -> DONE (mode 0); IDLE -> PP0 -> PP1 -> DONE (mode 1).
//   DONE -> IDLE on res_valid_o & res_ready_i.
//  Accept: in_valid_i & in_ready_o in IDLE latches a_i, b_i and mode_i, clears the accumulator
//   and goes to PP0. in_valid_i is ignored outside IDLE.
//  Byte operand extension to 9 bits:
//   - low bytes: always zero-extended in mode 0;
//   - high bytes: sign-extended iff SIGNED_EN;
//   - mode 1: every byte is a lane top, so it is sign-extended iff SIGNED_EN.
//   Each 9x9 product is 18 bits; it is sign-extended to 32 bits before shifting.
//  Mode 0 schedule (one multiply and accumulate per state):
//   PP0 ALBL<<0; PP1 ALBH<<8; PP2 AHBL<<8; PP3 AHBH<<16.
//   Accumulator is 32 bits and wraps; the final value is the exact 32-bit product.
//  Mode 1 schedule: PP0 lane0=AL*BL -> acc[15:0]; PP1 lane1=AH*BH -> acc[31:16].
//   Each lane keeps the low 16 bits of its product; there is no carry between lanes.
//  Latency: accept at edge T -> res_valid_o high after edge T+5 (mode 0) or T+3 (mode 1).
//  Output hold: in DONE, result_o and res_valid_o stay stable until res_ready_i.
//   The handshake edge moves to IDLE: res_valid_o=0 and in_ready_o=1 next cycle.
//   result_o keeps its last value.
//   No new operand is accepted in the handoff cycle, so back-to-back throughput is one result
//   per 6 cycles (mode 0) or 4 cycles (mode 1).
//  op_count_o: increments on each res_valid_o & res_ready_i edge; CNT_W all-ones + 1 -> 0.
//  Reset mid-operation: rst_i in any state aborts the operation and restores every reset value
//   on that edge. A partial result is never presented.
//  Simultaneous rst_i with a handshake: reset wins; op_count_o=0, the operation is not counted.
// TESTING
//  1 mode0: a=0xFFFF, b=0x0002 -> result_o=0xFFFFFFFE, res_valid_o 5 cycles after accept.
//  2 mode0: a=0x8000, b=0x8000 -> 0x40000000; a=0x7FFF, b=0x7FFF -> 0x3FFF0001.
//    With SIGNED_EN=0: a=0xFFFF, b=0xFFFF -> 0xFFFE0001.
//  3 mode1: a=0x7F80, b=0x0202 -> 0x00FEFF00 (lane1 127*2, lane0 -128*2), latency 3.
//  4 Backpressure: hold res_ready_i=0 for 4 cycles in DONE.
//    -> result_o/res_valid_o stable, in_ready_o=0, in_valid_i ignored.
//    Release -> IDLE next cycle, op_count_o +1.
//  5 Reset in PP2 of a=0x1234, b=0x5678 -> next cycle IDLE with all reset values.
//    Then a=0x0003, b=0xFFFD -> 0xFFFFFFF7.
//  6 CNT_W=4: 17 back-to-back ops with random mode/operands -> op_count_o ends at 1.
//    Every result matches the reference model.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle sequencer that time-shares one 9x9 signed multiplier across byte partial products.
// Latency: operands accepted at edge T; res_valid_o rises after edge T+4 (mode 0) / T+2 (mode 1),
//          so it is first sampled high by edge T+5 / T+3. Result is held in DONE until res_ready_i.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i / in_ready_o    operand handshake (ready only in IDLE), with mode_i, a_i, b_i
//   res_valid_o / res_ready_i  result handshake, result_o held stable while waiting
//   busy_o                     high outside IDLE
//   op_count_o                 number of results handed off, wraps modulo 2^CNT_W
//
// Mode 0 computes the exact 32-bit 16x16 product as four byte partial products. The low bytes
// carry no sign, so they enter the 9-bit multiplier zero-extended. Mode 1 computes two
// independent 8x8 lane products, each kept to 16 bits.

module mult_seq_ctrl #(
    parameter bit          SIGNED_EN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             mode_i,
    input  logic [15:0]      a_i,
    input  logic [15:0]      b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      result_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PP0  = 3'd1,
        ST_PP1  = 3'd2,
        ST_PP2  = 3'd3,
        ST_PP3  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Widen one operand byte to the 9-bit signed multiplier input.
    function automatic logic [8:0] ext9(input logic [7:0] b8, input logic sx);
        return {sx & b8[7], b8};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [15:0]        a_q,         a_d;
    logic [15:0]        b_q,         b_d;
    logic               mode_q,      mode_d;
    logic [31:0]        acc_q,       acc_d;
    logic [31:0]        result_q,    result_d;
    logic               res_valid_q, res_valid_d;
    logic               in_ready_q,  in_ready_d;
    logic               busy_q,      busy_d;
    logic [CNT_W-1:0]   op_count_q,  op_count_d;

    // ------------------------------------------------------------------
    // Shared multiplier datapath
    // ------------------------------------------------------------------
    logic signed [8:0]  mul_x;
    logic signed [8:0]  mul_y;
    logic signed [17:0] mul_p;
    logic [31:0]        pp_ext;

    logic [7:0] a_lo, a_hi, b_lo, b_hi;

    always_comb begin
        a_lo = a_q[7:0];
        a_hi = a_q[15:8];
        b_lo = b_q[7:0];
        b_hi = b_q[15:8];
    end

    // Operand selection per schedule step. In mode 1 every byte is the top of
    // its lane, so each one is sign-extended when signed operation is enabled.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            ST_PP0: begin
                if (mode_q) begin
                    mul_x = ext9(a_lo, SIGNED_EN);
                    mul_y = ext9(b_lo, SIGNED_EN);
                end else begin
                    mul_x = ext9(a_lo, 1'b0);
                    mul_y = ext9(b_lo, 1'b0);
                end
            end
            ST_PP1: begin
                if (mode_q) begin
                    mul_x = ext9(a_hi, SIGNED_EN);
                    mul_y = ext9(b_hi, SIGNED_EN);
                end else begin
                    mul_x = ext9(a_lo, 1'b0);
                    mul_y = ext9(b_hi, SIGNED_EN);
                end
            end
            ST_PP2: begin
                mul_x = ext9(a_hi, SIGNED_EN);
                mul_y = ext9(b_lo, 1'b0);
            end
            ST_PP3: begin
                mul_x = ext9(a_hi, SIGNED_EN);
                mul_y = ext9(b_hi, SIGNED_EN);
            end
            default: begin
                mul_x = '0;
                mul_y = '0;
            end
        endcase
    end

    always_comb begin
        mul_p  = mul_x * mul_y;
        // Sign-extend before alignment so negative partial products subtract
        // correctly from the wrapping 32-bit accumulator.
        pp_ext = {{14{mul_p[17]}}, mul_p};
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        result_d    = result_q;
        res_valid_d = res_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        op_count_d  = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    a_d        = a_i;
                    b_d        = b_i;
                    mode_d     = mode_i;
                    acc_d      = '0;
                    state_d    = ST_PP0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            ST_PP0: begin
                if (mode_q) begin
                    // Lane 0 keeps only its low 16 bits; nothing spills into lane 1.
                    acc_d = {acc_q[31:16], mul_p[15:0]};
                end else begin
                    acc_d = acc_q + pp_ext;
                end
                state_d = ST_PP1;
            end

            ST_PP1: begin
                if (mode_q) begin
                    acc_d       = {mul_p[15:0], acc_q[15:0]};
                    state_d     = ST_DONE;
                    result_d    = acc_d;
                    res_valid_d = 1'b1;
                end else begin
                    acc_d   = acc_q + (pp_ext << 8);
                    state_d = ST_PP2;
                end
            end

            ST_PP2: begin
                acc_d   = acc_q + (pp_ext << 8);
                state_d = ST_PP3;
            end

            ST_PP3: begin
                acc_d       = acc_q + (pp_ext << 16);
                state_d     = ST_DONE;
                result_d    = acc_d;
                res_valid_d = 1'b1;
            end

            ST_DONE: begin
                // result_q is left untouched on handoff so result_o keeps its last value.
                if (res_ready_i) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign res_valid_o = res_valid_q;
    assign result_o    = result_q;
    assign busy_o      = busy_q;
    assign op_count_o  = op_count_q;

endmodule
